// File: rtl/cmac_tx_sink_monitor.sv
// AXI4-Stream sink for the CMAC TX egress stream with packet/byte/error counters,
// drop-test and tkeep-format violation flags, and an AXI4-Lite register responder.
module cmac_tx_sink_monitor #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 32
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser_err,

    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_awaddr,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    input  logic [31:0]       s_axil_wdata,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    input  logic [31:0]       s_axil_araddr,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,

    output logic              violation
);

    localparam int BEAT_W = $clog2(KEEP_W + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              alive;
    logic              rx_en;
    logic              expect_drop;

    logic              aw_latched;
    logic              w_latched;
    logic [7:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              wr_commit;
    logic              ctrl_write;
    logic              clear;

    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [47:0]       byte_cnt;
    logic [15:0]       cur_len;
    logic [15:0]       last_len;
    logic              in_pkt;
    logic              drop_viol;
    logic              keep_viol;
    logic [15:0]       byte_hi_shadow;

    logic              beat_acc;
    logic [BEAT_W-1:0] beat_bytes;
    logic [16:0]       len_sum;
    logic [15:0]       len_sat;
    logic              keep_contig;
    logic              keep_bad;

    logic              ar_hs;
    logic [31:0]       rd_word;
    logic              unused_bits;

    function automatic logic addr_mapped(input logic [7:0] a);
        return (a[1:0] == 2'b00) && (a <= 8'h18);
    endfunction

    assign unused_bits = ^{s_axis_tdata, s_axil_awaddr[31:8], s_axil_wdata[31:3], s_axil_araddr[31:8]};

    // Ready outputs stay low while in reset and for the first cycle after release.
    assign s_axil_awready = alive && !aw_latched && !s_axil_bvalid;
    assign s_axil_wready  = alive && !w_latched && !s_axil_bvalid;
    assign s_axil_arready = alive && !s_axil_rvalid;

    assign wr_commit  = aw_latched && w_latched;
    assign ctrl_write = wr_commit && (wr_addr == 8'h00);
    assign clear      = ctrl_write && wr_data[2];
    assign ar_hs      = s_axil_arvalid && s_axil_arready;

    assign beat_acc   = s_axis_tvalid && s_axis_tready;
    assign violation  = drop_viol || keep_viol;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            beat_bytes = beat_bytes + BEAT_W'(s_axis_tkeep[i]);
        end
    end

    assign len_sum     = {1'b0, cur_len} + 17'(beat_bytes);
    assign len_sat     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    // A valid tkeep is a run of ones starting at byte 0, so tkeep+1 shares no set bit with it.
    assign keep_contig = ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) == '0);
    assign keep_bad    = (s_axis_tkeep == '0) || !keep_contig ||
                         (!s_axis_tlast && (s_axis_tkeep != '1));

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            alive         <= 1'b0;
            aw_latched    <= 1'b0;
            w_latched     <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            rx_en         <= 1'b0;
            expect_drop   <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            alive         <= 1'b1;
            s_axis_tready <= rx_en;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_latched <= 1'b1;
                wr_addr    <= s_axil_awaddr[7:0];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_latched <= 1'b1;
                wr_data   <= s_axil_wdata;
            end
            if (wr_commit) begin
                aw_latched    <= 1'b0;
                w_latched     <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= addr_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                if (ctrl_write) begin
                    rx_en       <= wr_data[0];
                    expect_drop <= wr_data[1];
                end
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Clear wins over a beat accepted in the same cycle; that beat is dropped from all counts.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            byte_cnt  <= '0;
            cur_len   <= '0;
            last_len  <= '0;
            in_pkt    <= 1'b0;
            drop_viol <= 1'b0;
            keep_viol <= 1'b0;
        end else if (clear) begin
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            byte_cnt  <= '0;
            cur_len   <= '0;
            last_len  <= '0;
            in_pkt    <= 1'b0;
            drop_viol <= 1'b0;
            keep_viol <= 1'b0;
        end else if (beat_acc) begin
            if (s_axis_tlast) begin
                pkt_cnt  <= pkt_cnt + CNT_W'(1);
                byte_cnt <= byte_cnt + 48'(len_sat);
                last_len <= len_sat;
                if (s_axis_tuser_err) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                cur_len  <= '0;
                in_pkt   <= 1'b0;
            end else begin
                cur_len  <= len_sat;
                in_pkt   <= 1'b1;
            end
            if (keep_bad) begin
                keep_viol <= 1'b1;
            end
            if (expect_drop) begin
                drop_viol <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (s_axil_araddr[7:0])
            8'h00:   rd_word = {30'b0, expect_drop, rx_en};
            8'h04:   rd_word = 32'(pkt_cnt);
            8'h08:   rd_word = byte_cnt[31:0];
            8'h0C:   rd_word = {16'b0, byte_hi_shadow};
            8'h10:   rd_word = 32'(err_cnt);
            8'h14:   rd_word = {29'b0, in_pkt, keep_viol, drop_viol};
            8'h18:   rd_word = {16'b0, last_len};
            default: rd_word = '0;
        endcase
    end

    // BYTE_HI is served from a shadow taken when BYTE_LO is read, keeping the 48-bit pair coherent.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            byte_hi_shadow <= '0;
        end else if (ar_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= addr_mapped(s_axil_araddr[7:0]) ? RESP_OKAY : RESP_SLVERR;
            if (s_axil_araddr[7:0] == 8'h08) begin
                byte_hi_shadow <= byte_cnt[47:32];
            end
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule
